// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, reset defaults and next-PC source selector for the fetch PC sequencer.
package pc_pkg;
   localparam int          PC_WIDTH             = 32;
   localparam int          INSTR_BYTES          = 4;
   localparam int unsigned DEFAULT_RESET_VECTOR = 32'h0000_0000;
   typedef enum logic [2:0] {SEL_RESET, SEL_REDIRECT, SEL_HOLD, SEL_RAS, SEL_SEQ} next_pc_sel_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; pushing when full overwrites the oldest entry,
// and push+pop together replaces the top (or pushes when empty).
module pc_ras #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           top_o,
   output logic                       empty_o,
   output logic [$clog2(RAS_DEPTH):0] count_o
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   logic [WIDTH-1:0] r_mem [RAS_DEPTH];
   logic [PW-1:0]    r_ptr;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    w_top_idx;
   // r_ptr is the next free slot; once full it also names the oldest entry
   assign w_top_idx = r_ptr - 1'b1;
   assign top_o     = r_mem[w_top_idx];
   assign empty_o   = r_count == '0;
   assign count_o   = r_count;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (push_i && pop_i && !empty_o) begin
         r_mem[w_top_idx] <= data_i;
      end else if (push_i) begin
         r_mem[r_ptr] <= data_i;
         r_ptr        <= r_ptr + 1'b1;
         if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + 1'b1;
      end else if (pop_i && !empty_o) begin
         r_ptr   <= w_top_idx;
         r_count <= r_count - 1'b1;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with redirect, stall, sequential and RAS-predicted next PC,
// plus registered misalign and RAS-miss pulses.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int          WIDTH        = PC_WIDTH,
   parameter int unsigned RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          RAS_DEPTH    = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       pc_write_i,
   input  logic                       redirect_i,
   input  logic [WIDTH-1:0]           redirect_pc_i,
   input  logic                       call_i,
   input  logic                       ret_i,
   output logic [WIDTH-1:0]           pc_o,
   output logic [WIDTH-1:0]           pc_plus4_o,
   output logic                       misalign_o,
   output logic                       ras_miss_o,
   output logic [$clog2(RAS_DEPTH):0] ras_count_o
);
   logic [WIDTH-1:0] r_pc, w_next_pc, w_top;
   logic             r_misalign, r_ras_miss;
   logic             w_adv, w_push, w_pop, w_empty;
   next_pc_sel_t     w_sel;
   // RAS only moves on a real, unredirected advance
   assign w_adv      = !rst_i && !redirect_i && pc_write_i;
   assign w_push     = w_adv && call_i;
   assign w_pop      = w_adv && ret_i;
   assign pc_plus4_o = r_pc + WIDTH'(INSTR_BYTES);
   assign pc_o       = r_pc;
   assign misalign_o = r_misalign;
   assign ras_miss_o = r_ras_miss;
   pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .data_i  (pc_plus4_o),
      .top_o   (w_top),
      .empty_o (w_empty),
      .count_o (ras_count_o)
   );
   always_comb begin
      w_sel = rst_i ? SEL_RESET : redirect_i ? SEL_REDIRECT : !pc_write_i ? SEL_HOLD :
              (ret_i && !w_empty) ? SEL_RAS : SEL_SEQ;
      w_next_pc = pc_plus4_o;
      case (w_sel)
         SEL_RESET:    w_next_pc = WIDTH'(RESET_VECTOR);
         SEL_REDIRECT: w_next_pc = {redirect_pc_i[WIDTH-1:2], 2'b00};
         SEL_HOLD:     w_next_pc = r_pc;
         SEL_RAS:      w_next_pc = w_top;
         default:      w_next_pc = pc_plus4_o;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc       <= WIDTH'(RESET_VECTOR);
         r_misalign <= 1'b0;
         r_ras_miss <= 1'b0;
      end else begin
         r_pc       <= w_next_pc;
         r_misalign <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
         r_ras_miss <= w_pop && w_empty;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios plus randomized traffic checked against a queue-based model.
module tb_pc_sequencer;
   logic        clk = 0, rst_i = 0, pc_write_i = 0, redirect_i = 0, call_i = 0, ret_i = 0;
   logic [31:0] redirect_pc_i = 0;
   logic [31:0] pc_o, pc_plus4_o;
   logic        misalign_o, ras_miss_o;
   logic [2:0]  ras_count_o;
   int          n_vec = 0, n_err = 0;
   logic [31:0] m_pc = 0;
   logic        m_mis = 0, m_miss = 0;
   logic [31:0] m_q[$];

   always #5 clk = ~clk;

   pc_sequencer #(.WIDTH(32), .RESET_VECTOR(0), .RAS_DEPTH(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .pc_write_i(pc_write_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .call_i(call_i), .ret_i(ret_i), .pc_o(pc_o),
      .pc_plus4_o(pc_plus4_o), .misalign_o(misalign_o), .ras_miss_o(ras_miss_o),
      .ras_count_o(ras_count_o)
   );

   // applies one cycle of inputs, advances the reference model, samples 1 ns after the edge
   task automatic cyc(input logic rst, input logic pw, input logic redir, input logic [31:0] rpc,
                      input logic call, input logic ret);
      logic [31:0] p4;
      rst_i = rst; pc_write_i = pw; redirect_i = redir; redirect_pc_i = rpc; call_i = call; ret_i = ret;
      p4 = m_pc + 32'd4;
      m_mis = 0; m_miss = 0;
      if (rst) begin
         m_pc = 0; m_q.delete();
      end else if (redir) begin
         m_pc = {rpc[31:2], 2'b00}; m_mis = rpc[1:0] != 0;
      end else if (pw) begin
         if (ret && m_q.size() > 0) begin
            m_pc = m_q[$]; void'(m_q.pop_back());
            if (call) m_q.push_back(p4);
         end else begin
            m_miss = ret; m_pc = p4;
            if (call) begin
               m_q.push_back(p4);
               if (m_q.size() > 4) void'(m_q.pop_front());
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      cyc(1, 0, 0, 0, 1, 1);
      cyc(1, 1, 1, 32'h55, 0, 0);
      n_vec++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", pc_o); end
      n_vec++; if (ras_count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", ras_count_o); end
      n_vec++; if ({misalign_o, ras_miss_o} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b exp 00", {misalign_o, ras_miss_o}); end
   endtask

   task automatic test_seq;
      for (int k = 1; k <= 3; k++) begin
         cyc(0, 1, 0, 0, 0, 0);
         n_vec++; if (pc_o !== 32'(4 * k)) begin n_err++; $display("FAIL seq_pc%0d got %h exp %h", k, pc_o, 32'(4 * k)); end
      end
      n_vec++; if (pc_plus4_o !== 32'h10) begin n_err++; $display("FAIL seq_plus4 got %h exp 10", pc_plus4_o); end
   endtask

   task automatic test_stall_redirect;
      cyc(0, 1, 1, 32'h20, 0, 0);
      cyc(0, 0, 0, 0, 1, 1);
      n_vec++; if (pc_o !== 32'h20 || ras_count_o !== 3'd0) begin n_err++; $display("FAIL stall_hold got pc %h cnt %0d exp 20 0", pc_o, ras_count_o); end
      n_vec++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL stall_mis got %b exp 0", misalign_o); end
      cyc(0, 0, 1, 32'h103, 0, 0);
      n_vec++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL redir_pc got %h exp 100", pc_o); end
      n_vec++; if (misalign_o !== 1'b1) begin n_err++; $display("FAIL redir_mis got %b exp 1", misalign_o); end
      cyc(0, 1, 0, 0, 0, 0);
      n_vec++; if (misalign_o !== 1'b0 || pc_o !== 32'h104) begin n_err++; $display("FAIL mis_pulse got mis %b pc %h exp 0 104", misalign_o, pc_o); end
   endtask

   task automatic test_call_ret;
      cyc(0, 1, 1, 32'h40, 0, 0);
      cyc(0, 1, 0, 0, 1, 0);
      n_vec++; if (pc_o !== 32'h44 || ras_count_o !== 3'd1) begin n_err++; $display("FAIL call_push got pc %h cnt %0d exp 44 1", pc_o, ras_count_o); end
      for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0, 0);
      n_vec++; if (pc_o !== 32'h80) begin n_err++; $display("FAIL call_seq got %h exp 80", pc_o); end
      cyc(0, 1, 0, 0, 0, 1);
      n_vec++; if (pc_o !== 32'h44 || ras_count_o !== 3'd0) begin n_err++; $display("FAIL ret_pop got pc %h cnt %0d exp 44 0", pc_o, ras_count_o); end
   endtask

   task automatic test_overflow;
      logic [31:0] exp_pc [5] = '{32'h14, 32'h10, 32'hC, 32'h8, 32'hC};
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 0);
      n_vec++; if (ras_count_o !== 3'd4 || pc_o !== 32'h14) begin n_err++; $display("FAIL ovf_full got cnt %0d pc %h exp 4 14", ras_count_o, pc_o); end
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 0, 0, 0, 1);
         n_vec++; if (pc_o !== exp_pc[i]) begin n_err++; $display("FAIL ovf_ret%0d got %h exp %h", i, pc_o, exp_pc[i]); end
         n_vec++; if (ras_miss_o !== (i == 4)) begin n_err++; $display("FAIL ovf_miss%0d got %b exp %b", i, ras_miss_o, i == 4); end
      end
      cyc(0, 1, 0, 0, 0, 0);
      n_vec++; if (ras_miss_o !== 1'b0) begin n_err++; $display("FAIL miss_pulse got %b exp 0", ras_miss_o); end
   endtask

   task automatic test_simultaneous;
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 1);
      n_vec++; if (pc_o !== 32'h4 || ras_count_o !== 3'd1 || ras_miss_o !== 1'b1) begin n_err++; $display("FAIL both_empty got pc %h cnt %0d miss %b exp 4 1 1", pc_o, ras_count_o, ras_miss_o); end
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h1FC, 0, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 1, 1, 32'h60, 0, 0);
      cyc(0, 1, 0, 0, 1, 1);
      n_vec++; if (pc_o !== 32'h200 || ras_count_o !== 3'd1) begin n_err++; $display("FAIL both_replace got pc %h cnt %0d exp 200 1", pc_o, ras_count_o); end
      cyc(0, 1, 0, 0, 0, 1);
      n_vec++; if (pc_o !== 32'h64 || ras_count_o !== 3'd0) begin n_err++; $display("FAIL new_top got pc %h cnt %0d exp 64 0", pc_o, ras_count_o); end
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 1, 1, 32'h300, 1, 1);
      n_vec++; if (pc_o !== 32'h300 || ras_count_o !== 3'd1) begin n_err++; $display("FAIL redir_ret got pc %h cnt %0d exp 300 1", pc_o, ras_count_o); end
      cyc(0, 1, 0, 0, 0, 1);
      n_vec++; if (pc_o !== 32'h68) begin n_err++; $display("FAIL ras_untouched got %h exp 68", pc_o); end
   endtask

   task automatic test_wrap_reset;
      cyc(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
      n_vec++; if (pc_plus4_o !== 32'h0) begin n_err++; $display("FAIL wrap_plus4 got %h exp 0", pc_plus4_o); end
      cyc(0, 1, 0, 0, 1, 0);
      n_vec++; if (pc_o !== 32'h0 || ras_count_o !== 3'd1) begin n_err++; $display("FAIL wrap_pc got pc %h cnt %0d exp 0 1", pc_o, ras_count_o); end
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0);
      n_vec++; if (pc_o !== 32'h0 || ras_count_o !== 3'd0) begin n_err++; $display("FAIL midrst got pc %h cnt %0d exp 0 0", pc_o, ras_count_o); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(3) == 0) ? $urandom : {$urandom_range(255), 2'b00};
         cyc($urandom_range(39) == 0, $urandom_range(3) != 0, $urandom_range(7) == 0, rpc,
             $urandom_range(2) == 0, $urandom_range(2) == 0);
         n_vec++; if (pc_o !== m_pc) begin n_err++; $display("FAIL rnd_pc@%0d got %h exp %h", i, pc_o, m_pc); end
         n_vec++; if (pc_plus4_o !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_plus4@%0d got %h exp %h", i, pc_plus4_o, m_pc + 32'd4); end
         n_vec++; if (ras_count_o !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_cnt@%0d got %0d exp %0d", i, ras_count_o, m_q.size()); end
         n_vec++; if ({misalign_o, ras_miss_o} !== {m_mis, m_miss}) begin n_err++; $display("FAIL rnd_flags@%0d got %b exp %b", i, {misalign_o, ras_miss_o}, {m_mis, m_miss}); end
      end
   endtask

   initial begin
      test_reset;
      test_seq;
      test_stall_redirect;
      test_call_ret;
      test_overflow;
      test_simultaneous;
      test_wrap_reset;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised fetch-stage program counter: holds the current PC and computes the next PC. Sources for the next PC are sequential increment, a resolved-branch/jump redirect from EX, or a return-address-stack (RAS) prediction. It sits in IF, replacing the plain write-enabled PC register. The hazard unit drives `pc_write_i`, EX drives the redirect, and decode drives the call/return hints.

## Interface
- `WIDTH`, 32, PC width in bits.
- `RESET_VECTOR`, 0, PC value loaded on reset; must be 4-byte aligned.
- `RAS_DEPTH`, 4, number of return-address entries; a power of two, ≥2.
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `pc_write_i`  in  1  1 = PC may advance; 0 = hold (stall).
- `redirect_i`  in  1  EX resolved a taken branch or jump; overrides everything except reset.
- `redirect_pc_i`  in  WIDTH  redirect target.
- `call_i`  in  1  instruction at `pc_o` is a call (jal); push `pc_o+4`.
- `ret_i`  in  1  instruction at `pc_o` is a return (jr $ra); pop the predicted target.
- `pc_o`  out  WIDTH  current fetch PC (registered).
- `pc_plus4_o`  out  WIDTH  `pc_o + 4`, combinational, modulo 2^WIDTH.
- `misalign_o`  out  1  registered one-cycle pulse: the last accepted redirect target had nonzero bits [1:0].
- `ras_miss_o`  out  1  registered one-cycle pulse: a `ret_i` was accepted while the RAS was empty.
- `ras_count_o`  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.

## Operation
- Next-PC priority, evaluated every cycle:
  - `rst_i`: load `RESET_VECTOR`.
  - `redirect_i`: load `{redirect_pc_i[WIDTH-1:2],2'b00}`. Applies even when `pc_write_i`=0.
  - `!pc_write_i`: hold.
  - `ret_i` with RAS non-empty: load the RAS top.
  - otherwise: load `pc_o+4`.
- Arithmetic is unsigned modulo 2^WIDTH. Incrementing from `{WIDTH{1}}-3` wraps to 0 with no flag.
- RAS operations occur only when `pc_write_i`=1, `redirect_i`=0 and `rst_i`=0. A redirect or stall leaves the RAS unchanged.
- Push (`call_i` only): write `pc_o+4` on top and increment the count.
  - When full, overwrite the oldest entry: the circular pointer advances and the count saturates at `RAS_DEPTH`.
- Pop (`ret_i` only): next PC = top; decrement the count.
  - When empty: next PC = `pc_o+4`, count stays 0, `ras_miss_o` pulses.
- `call_i` and `ret_i` both set: next PC = old top, then top is replaced by `pc_o+4`; count unchanged.
  - If empty: next PC = `pc_o+4`, push `pc_o+4`, count becomes 1, `ras_miss_o` pulses.
- Reset state: `pc_o`=`RESET_VECTOR`, `ras_count_o`=0, RAS pointer 0, `misalign_o`=0, `ras_miss_o`=0. RAS entry contents are don't-care.

## Timing
- All outputs are registered except `pc_plus4_o`. Decisions are sampled at edge N and visible on `pc_o` after edge N.
- Redirect-to-new-PC latency is 1 cycle.
- `misalign_o` and `ras_miss_o` are high for exactly the cycle after the causing edge.
- Reset asserted mid-stream takes effect at the next edge regardless of other inputs. The RAS is emptied in that same edge.
- There is no handshake: `call_i` and `ret_i` are qualified by `pc_write_i` in the same cycle. Upstream holds them stable while stalled.

## Structure
- Shared package `pc_pkg`:
  - `PC_WIDTH` default
  - `INSTR_BYTES`=4
  - `DEFAULT_RESET_VECTOR`
  - enum `next_pc_sel_t` {SEL_RESET, SEL_REDIRECT, SEL_HOLD, SEL_RAS, SEL_SEQ}
- One sub-module, `pc_ras`: circular stack with a top pointer and a saturating count, with push/pop/replace ports. Parameters are `WIDTH` and `RAS_DEPTH`.
- The top level holds the PC register, the next-PC mux and the flag registers.

## Test plan
- Reset and sequential: `rst_i`=1 for 2 cycles, then `pc_write_i`=1 for 3 cycles. Required: `pc_o` = 0, 4, 8, 0xC; `pc_plus4_o`=0x10.
- Stall vs redirect: at PC 0x20 hold `pc_write_i`=0 for 2 cycles, with `redirect_i`=1, `redirect_pc_i`=0x103 in the second cycle. Required: `pc_o` stays 0x20, then becomes 0x100; `misalign_o` pulses once.
- Call/return: call at 0x40, sequential to 0x80, ret at 0x80. Required: `pc_o` after the ret = 0x44; `ras_count_o` goes 1 then 0.
- RAS overflow (`RAS_DEPTH`=4): 5 calls at PCs 0x0, 0x4, 0x8, 0xC, 0x10, then 5 rets. Required: pops return 0x14, 0x10, 0xC, 0x8. The fifth ret goes sequential and `ras_miss_o` pulses.
- Simultaneous events:
  - `call_i`=`ret_i`=1 with top=0x200 at PC 0x60: required next PC 0x200, new top 0x64, count unchanged.
  - `redirect_i` with `ret_i`: required PC = redirect target, RAS untouched.
- Wrap and reset mid-op: at PC 0xFFFFFFFC advance once, then assert `rst_i` with `call_i`=1. Required: PC 0x0, then `RESET_VECTOR`, `ras_count_o`=0.
